trng_word_reader: RTL and testbench

Consumer end of the 32-bit parallel TRNG word interface. Samples word_valid/rand_word from the TRNG array and applies a repetition-count health test. Buffers accepted words in a small FIFO and delivers them downstream on a valid/ready stream. Sits between the TRNG array and any crypto/DRBG consumer; reports drops and health failures.

---
 rtl/trng_pkg.sv | 11 +
 rtl/trng_fifo.sv | 54 +++++
 rtl/trng_word_reader.sv | 112 +++++++++++
 tb/tb_trng_word_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared constants and word type for the TRNG array and its consumers.
package trng_pkg;

    localparam int TRNG_WORD_W    = 32;
    localparam int TRNG_DEPTH     = 8;
    localparam int TRNG_REP_LIMIT = 4;
    localparam int TRNG_CNT_W     = 16;

    typedef logic [TRNG_WORD_W-1:0] trng_word_t;

endpackage

// File: rtl/trng_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head reads as zero when empty.
module trng_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level,
    output logic [W-1:0]  o_head
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == LW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + LW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - LW'(1);
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides what is readable.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/trng_word_reader.sv
// TRNG word consumer: capture stage, repetition-count health test, FWFT buffer, drop counter.
module trng_word_reader
    import trng_pkg::*;
#(
    parameter int WORD_W    = TRNG_WORD_W,
    parameter int DEPTH     = TRNG_DEPTH,
    parameter int REP_LIMIT = TRNG_REP_LIMIT,
    parameter int CNT_W     = TRNG_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   word_valid,
    input  logic [WORD_W-1:0]      rand_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   health_fail,
    input  logic                   health_clr,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic              r_cap_valid;
    logic [WORD_W-1:0] r_cap_word;
    logic              r_last_valid;
    logic [WORD_W-1:0] r_last_word;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_health_fail;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_match;
    logic [REP_W-1:0]  w_rep_next;
    logic              w_trip;
    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cap_valid <= 1'b0;
            r_cap_word  <= '0;
        end else begin
            r_cap_valid <= en && word_valid;
            if (en && word_valid) r_cap_word <= rand_word;
        end
    end

    assign w_match = r_last_valid && (r_cap_word == r_last_word);

    always_comb begin
        w_rep_next = REP_W'(1);
        if (w_match) w_rep_next = (r_rep_cnt >= REP_MAX) ? REP_MAX : r_rep_cnt + REP_W'(1);
    end

    assign w_trip     = r_cap_valid && (w_rep_next == REP_MAX);
    assign w_push_req = r_cap_valid && !w_trip && !r_health_fail;
    assign w_pop      = out_valid && out_ready;
    assign w_drop     = w_push_req && w_full && !w_pop;

    // A clear forgets the run history; a coincident trip still leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_valid  <= 1'b0;
            r_last_word   <= '0;
            r_rep_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else begin
            if (health_clr) begin
                r_last_valid <= 1'b0;
                r_rep_cnt    <= '0;
            end else if (r_cap_valid) begin
                r_last_valid <= 1'b1;
                r_last_word  <= r_cap_word;
                r_rep_cnt    <= w_rep_next;
            end
            if (w_trip)          r_health_fail <= 1'b1;
            else if (health_clr) r_health_fail <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                            r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end

    trng_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_data  (r_cap_word),
        .i_pop   (w_pop),
        .i_flush (w_trip),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level),
        .o_head  (out_data)
    );

    assign out_valid   = !w_empty;
    assign health_fail = r_health_fail;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_trng_word_reader.sv
// Self-checking bench for trng_word_reader: vector table, directed corners, randomized run vs queue model.
module tb_trng_word_reader;
    import trng_pkg::*;

    localparam int DEPTH     = 8;
    localparam int REP_LIMIT = 4;
    localparam int CNT_W     = 16;
    localparam int DROP_MAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   en = 1'b0;
    logic                   word_valid = 1'b0;
    trng_word_t             rand_word = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    trng_word_t             out_data;
    logic [$clog2(DEPTH):0] level;
    logic                   health_fail;
    logic                   health_clr = 1'b0;
    logic [CNT_W-1:0]       drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    trng_word_reader #(
        .WORD_W    (TRNG_WORD_W),
        .DEPTH     (DEPTH),
        .REP_LIMIT (REP_LIMIT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .word_valid  (word_valid),
        .rand_word   (rand_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .health_fail (health_fail),
        .health_clr  (health_clr),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is a queue, the health test looks back over the
    // history of captured words since the last clear.
    trng_word_t m_q[$];
    trng_word_t m_hist[$];
    bit         m_cap_v;
    trng_word_t m_cap_w;
    bit         m_health;
    int         m_drops;

    function automatic int run_len();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0 && n < REP_LIMIT; i--) begin
            if (m_hist[i] == m_hist[m_hist.size()-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hist.delete();
        m_cap_v  = 1'b0;
        m_cap_w  = '0;
        m_health = 1'b0;
        m_drops  = 0;
    endtask

    task automatic model_step(input bit s_en, input bit s_wv, input trng_word_t s_word,
                              input bit s_rdy, input bit s_clr);
        bit old_h = m_health;
        bit trip  = 1'b0;
        if (s_rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (m_cap_v) begin
            m_hist.push_back(m_cap_w);
            if (m_hist.size() > REP_LIMIT) void'(m_hist.pop_front());
            trip = (run_len() == REP_LIMIT);
            if (trip) begin
                m_health = 1'b1;
                m_q.delete();
            end else if (!old_h) begin
                if (m_q.size() < DEPTH)   m_q.push_back(m_cap_w);
                else if (m_drops < DROP_MAX) m_drops++;
            end
        end
        if (s_clr) begin
            m_hist.delete();
            if (!trip) m_health = 1'b0;
        end
        m_cap_v = s_en && s_wv;
        if (m_cap_v) m_cap_w = s_word;
    endtask

    task automatic compare_model();
        check("mdl.out_valid",   out_valid,   m_q.size() > 0);
        check("mdl.out_data",    out_data,    (m_q.size() > 0) ? m_q[0] : '0);
        check("mdl.level",       level,       m_q.size());
        check("mdl.health_fail", health_fail, m_health);
        check("mdl.drop_cnt",    drop_cnt,    m_drops);
    endtask

    // Drive inputs, let one rising edge happen, update the model, compare 1 ns later.
    task automatic cycle(input bit c_en, input bit c_wv, input trng_word_t c_word,
                         input bit c_rdy, input bit c_clr);
        en         = c_en;
        word_valid = c_wv;
        rand_word  = c_word;
        out_ready  = c_rdy;
        health_clr = c_clr;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step(c_en, c_wv, c_word, c_rdy, c_clr);
        #1;
        compare_model();
    endtask

    task automatic idle(input bit c_rdy);
        cycle(1'b0, 1'b0, '0, c_rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b1;
    endtask

    typedef struct {
        bit         en;
        bit         wv;
        trng_word_t word;
        bit         rdy;
        bit         clr;
        bit         e_valid;
        trng_word_t e_data;
        int         e_level;
        bit         e_health;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        trng_word_t last_cap;
        bit         have_last;

        // Three words with out_ready high, then a 4x repeat trip, clear, and restart.
        tbl[0]  = '{1, 1, 32'h11111111, 1, 0, 0, 32'h0,        0, 0};
        tbl[1]  = '{1, 1, 32'h22222222, 1, 0, 1, 32'h11111111, 1, 0};
        tbl[2]  = '{1, 1, 32'h33333333, 1, 0, 1, 32'h22222222, 1, 0};
        tbl[3]  = '{0, 0, 32'h0,        1, 0, 1, 32'h33333333, 1, 0};
        tbl[4]  = '{0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0};
        tbl[5]  = '{1, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 0};
        tbl[6]  = '{1, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 1, 0};
        tbl[7]  = '{1, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 2, 0};
        tbl[8]  = '{1, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 3, 0};
        tbl[9]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1};
        tbl[10] = '{1, 1, 32'h12345678, 0, 0, 0, 32'h0,        0, 1};
        tbl[11] = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1};
        tbl[12] = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0};
        tbl[13] = '{1, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 0};
        tbl[14] = '{1, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 1, 0};
        tbl[15] = '{1, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 2, 0};
        tbl[16] = '{0, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 3, 0};
        tbl[17] = '{0, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 3, 0};

        do_reset();
        check("rst.out_valid",   out_valid,   0);
        check("rst.out_data",    out_data,    0);
        check("rst.level",       level,       0);
        check("rst.health_fail", health_fail, 0);
        check("rst.drop_cnt",    drop_cnt,    0);

        for (int i = 0; i < NV; i++) begin
            cycle(tbl[i].en, tbl[i].wv, tbl[i].word, tbl[i].rdy, tbl[i].clr);
            check($sformatf("tbl%0d.out_valid", i),   out_valid,   tbl[i].e_valid);
            check($sformatf("tbl%0d.out_data", i),    out_data,    tbl[i].e_data);
            check($sformatf("tbl%0d.level", i),       level,       tbl[i].e_level);
            check($sformatf("tbl%0d.health_fail", i), health_fail, tbl[i].e_health);
            check($sformatf("tbl%0d.drop_cnt", i),    drop_cnt,    0);
        end

        // Overflow: ten distinct words into a stalled 8-deep buffer, then drain in order.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("ovf.level",    level,    8);
        check("ovf.drop_cnt", drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf.drain%0d", i), out_data, 32'hA000_0000 + i);
            idle(1'b1);
        end
        check("ovf.empty_level", level,     0);
        check("ovf.empty_valid", out_valid, 0);

        // Full buffer with simultaneous push and pop: occupancy holds, nothing lost.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 32'hB000_0000 + i, 1'b0, 1'b0);
        check("full.level", level, 8);
        for (int i = 9; i < 14; i++) begin
            cycle(1'b1, 1'b1, 32'hB000_0000 + i, 1'b1, 1'b0);
            check($sformatf("full.level%0d", i), level,    8);
            check($sformatf("full.drop%0d", i),  drop_cnt, 0);
        end
        for (int i = 5; i < 14; i++) begin
            check($sformatf("full.order%0d", i), out_data, 32'hB000_0000 + i);
            idle(1'b1);
        end
        check("full.drained", level, 0);

        // Reset mid-stream with five buffered words, then en=0 must block capture.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'hC000_0000 + i, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("mid.level_before", level, 5);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 32'hC0FF_EE00, 1'b1, 1'b0);
        check("mid.out_valid",   out_valid,   0);
        check("mid.level",       level,       0);
        check("mid.drop_cnt",    drop_cnt,    0);
        check("mid.health_fail", health_fail, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hE000_0000 + i, 1'b0, 1'b0);
        check("en0.level",     level,     0);
        check("en0.out_valid", out_valid, 0);

        // Randomized traffic biased toward repeats so the health test trips now and then.
        have_last = 1'b0;
        last_cap  = '0;
        for (int n = 0; n < 1500; n++) begin
            bit         r_en, r_wv, r_rdy, r_clr;
            trng_word_t w;
            int         pick;
            rst   = ($urandom_range(0, 199) != 0);
            r_en  = ($urandom_range(0, 9) != 0);
            r_wv  = ($urandom_range(0, 4) != 0);
            r_rdy = ($urandom_range(0, 1) != 0);
            r_clr = ($urandom_range(0, 39) == 0);
            pick  = $urandom_range(0, 9);
            if (pick < 6 && have_last) w = last_cap;
            else if (pick < 8)         w = 32'h5A5A_0000 + $urandom_range(0, 3);
            else                       w = $urandom;
            if (!rst) have_last = 1'b0;
            else if (r_en && r_wv) begin
                last_cap  = w;
                have_last = 1'b1;
            end
            cycle(r_en, r_wv, w, r_rdy, r_clr);
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
